banked_sort_engine: RTL and testbench
=====================================

BANKED_SORT_ENGINE -- requirements
Module: banked_sort_engine

Interface
REQ-001 SHALL have parameter N, default 16, max entries per bank (power of 2, >=2).
REQ-002 SHALL have parameter W, default 32, data word width.
REQ-003 SHALL have parameter BANK_N, default 2, number of banks (>=2).
REQ-004 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  enqueue word valid.
- in_dat  input  W  enqueue word.
- in_last  input  1  final word of current list.
- in_desc  input  1  sort order for list (1 = descending); sampled with the list's first word.
- in_rdy  output  1  enqueue accept.
- out_vld  output  1  dequeue word valid.
- out_dat  output  W  sorted word.
- out_last  output  1  final word of list.
- out_err  output  1  list was truncated at N.
- out_rdy  input  1  dequeue accept.
- busy  output  1  any bank not IDLE.

Function
REQ-005 SHALL keep per bank: status (IDLE, LOADING, READY, SORTING, SORTED, UNLOADING), count n of $clog2(N)+1 bits, error flag, desc flag, N x W storage.
REQ-006 SHALL keep load, sort and unload bank pointers, each advancing modulo BANK_N after finishing a bank, so lists exit in arrival order.
REQ-007 SHALL transfer on in_vld & in_rdy; in_rdy = 1 iff load-pointer bank is IDLE or LOADING.
REQ-008 First accepted word SHALL move the bank IDLE->LOADING and capture in_desc; each word is written at index n, then n increments.
REQ-009 Word with in_last SHALL move the bank to READY; the Nth word without in_last SHALL also move it to READY with error=1, and following words start the next bank.
REQ-010 Sort engine SHALL take the sort-pointer bank READY->SORTING the cycle after READY is observed; only one bank sorts at a time.
REQ-011 Sorting SHALL be bubble sort, one compare-swap per cycle: pass p compares index i with i+1 for i = 0..n-2-p; swap when a[i] > a[i+1] (ascending) or a[i] < a[i+1] (descending), unsigned compare.
REQ-012 Without early exit, n >= 2 SHALL take exactly n(n-1)/2 compare cycles; n = 1 takes zero; bank moves to SORTED the cycle after the last compare.
REQ-013 Equal keys SHALL not swap (stable).
REQ-014 Unload SHALL take the unload-pointer bank SORTED->UNLOADING, present index 0 with out_vld, and advance on out_vld & out_rdy.
REQ-015 out_dat/out_last/out_err SHALL hold stable while out_vld & !out_rdy.
REQ-016 out_last SHALL assert on index n-1; its handshake returns the bank to IDLE and clears n, error and desc.
REQ-017 Load, sort and unload of different banks SHALL proceed concurrently in the same cycle.
REQ-018 All banks non-IDLE SHALL hold in_rdy = 0 until the load-pointer bank returns to IDLE.
REQ-019 busy = OR over banks of (status != IDLE), registered-state derived, no combinational path from inputs.

Reset
REQ-020 rst_n low SHALL asynchronously force all banks IDLE, n = 0, flags 0, pointers 0; in_rdy, out_vld, out_last, out_err, busy = 0; storage is not reset.
REQ-021 Reset mid-operation SHALL discard all partial, sorting and unloading lists; in_rdy = 1 from the first clk edge after rst_n deasserts.

Configuration
REQ-022 Macro BANKED_SORT_EARLY_EXIT_EN defined: sort SHALL end after the first pass with no swap (already-ordered list of n takes n-1 compare cycles); undefined: always the full n(n-1)/2 cycles per REQ-012; output data identical either way.

Verification
REQ-023 Load 5,3,9,1 (last on 1), desc=0, out_rdy=1 -> out 1,3,5,9, out_last on 9, out_err=0; sort phase 6 compare cycles (macro off).
REQ-024 Load 16 words 0..15 with desc=1 and no last -> out 15..0, out_err=1 on all beats; a 17th word 7 with last forms list "7" emitted next.
REQ-025 Three back-to-back lists with out_rdy=0 -> in_rdy drops after the second list, rises the cycle the first list's out_last handshakes; outputs in arrival order.
REQ-026 Single-word list 42 -> SORTED with zero compare cycles, out_dat=42, out_last=1.
REQ-027 Macro on, sorted input 1,2,3,4 -> 3 compare cycles; macro off -> 6; same output.
REQ-028 rst_n low during SORTING and during UNLOADING with out_rdy toggling -> all outputs 0 immediately, busy=0, next list sorts correctly.

Source files
------------

// File: rtl/banked_sort_engine.sv
// Banked list sorter: loads lists into rotating banks, bubble-sorts one bank at a time, unloads in arrival order.
// Optional early-exit sort termination via macro BANKED_SORT_EARLY_EXIT_EN.
module banked_sort_engine #(
    parameter int N      = 16,
    parameter int W      = 32,
    parameter int BANK_N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         in_last,
    input  logic         in_desc,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         out_last,
    output logic         out_err,
    input  logic         out_rdy,
    output logic         busy
);
    localparam int IW = $clog2(N);
    localparam int NW = IW + 1;
    localparam int PW = (BANK_N > 1) ? $clog2(BANK_N) : 1;

    typedef enum logic [2:0] {
        B_IDLE, B_LOADING, B_READY, B_SORTING, B_SORTED, B_UNLOADING
    } bank_st_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} sort_st_t;
    typedef enum logic {U_IDLE, U_RUN} unld_st_t;

    bank_st_t        st     [BANK_N];
    logic [NW-1:0]   cnt    [BANK_N];
    logic            err_f  [BANK_N];
    logic            desc_f [BANK_N];
    logic [W-1:0]    mem    [BANK_N][N];

    logic [PW-1:0]   ld_ptr, so_ptr, ul_ptr;
    logic            run_q;
    sort_st_t        s_st;
    logic [IW-1:0]   i_q, lim_q;
    logic            swp_q;
    unld_st_t        u_st;
    logic [IW-1:0]   u_idx;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BANK_N - 1)) ? '0 : p + PW'(1);
    endfunction

    // Load side
    logic          ld_fire;
    logic [NW-1:0] ld_n;
    logic          ld_full;

    assign in_rdy  = run_q && (st[ld_ptr] == B_IDLE || st[ld_ptr] == B_LOADING);
    assign ld_fire = in_vld && in_rdy;
    assign ld_n    = cnt[ld_ptr];
    assign ld_full = (ld_n == NW'(N - 1));

    // Sort datapath: one adjacent compare-swap per cycle
    logic [IW-1:0] i_nxt;
    logic [W-1:0]  cmp_a, cmp_b;
    logic          do_swap, pass_end, swp_any, early, sort_done;

    assign i_nxt    = i_q + IW'(1);
    assign cmp_a    = mem[so_ptr][i_q];
    assign cmp_b    = mem[so_ptr][i_nxt];
    assign do_swap  = (s_st == S_RUN) && (desc_f[so_ptr] ? (cmp_a < cmp_b) : (cmp_a > cmp_b));
    assign pass_end = (i_q == lim_q);
    assign swp_any  = swp_q || do_swap;
`ifdef BANKED_SORT_EARLY_EXIT_EN
    assign early    = !swp_any;
`else
    assign early    = 1'b0;
`endif
    assign sort_done = pass_end && ((lim_q == '0) || early);

    logic [IW-1:0] u_nxt;
    assign u_nxt = u_idx + IW'(1);

    // Storage has no reset; load and sort always address different banks
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[ld_ptr][ld_n[IW-1:0]] <= in_dat;
        end
        if (do_swap) begin
            mem[so_ptr][i_q]   <= cmp_b;
            mem[so_ptr][i_nxt] <= cmp_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < BANK_N; b++) begin
                st[b]     <= B_IDLE;
                cnt[b]    <= '0;
                err_f[b]  <= 1'b0;
                desc_f[b] <= 1'b0;
            end
            ld_ptr   <= '0;
            so_ptr   <= '0;
            ul_ptr   <= '0;
            run_q    <= 1'b0;
            s_st     <= S_IDLE;
            i_q      <= '0;
            lim_q    <= '0;
            swp_q    <= 1'b0;
            u_st     <= U_IDLE;
            u_idx    <= '0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            run_q <= 1'b1;

            if (ld_fire) begin
                cnt[ld_ptr] <= ld_n + NW'(1);
                if (st[ld_ptr] == B_IDLE) begin
                    st[ld_ptr]     <= B_LOADING;
                    desc_f[ld_ptr] <= in_desc;
                end
                if (in_last || ld_full) begin
                    st[ld_ptr]    <= B_READY;
                    err_f[ld_ptr] <= !in_last;
                    ld_ptr        <= nxt(ld_ptr);
                end
            end

            case (s_st)
                S_IDLE: begin
                    if (st[so_ptr] == B_READY) begin
                        st[so_ptr] <= B_SORTING;
                        i_q        <= '0;
                        swp_q      <= 1'b0;
                        lim_q      <= IW'(cnt[so_ptr] - NW'(2));
                        s_st       <= (cnt[so_ptr] < NW'(2)) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (sort_done) begin
                        s_st <= S_FIN;
                    end else if (pass_end) begin
                        i_q   <= '0;
                        lim_q <= lim_q - IW'(1);
                        swp_q <= 1'b0;
                    end else begin
                        i_q   <= i_nxt;
                        swp_q <= swp_any;
                    end
                end
                S_FIN: begin
                    st[so_ptr] <= B_SORTED;
                    so_ptr     <= nxt(so_ptr);
                    s_st       <= S_IDLE;
                end
                default: s_st <= S_IDLE;
            endcase

            // Outputs are registered so they hold while the consumer stalls
            case (u_st)
                U_IDLE: begin
                    if (st[ul_ptr] == B_SORTED) begin
                        st[ul_ptr] <= B_UNLOADING;
                        u_idx      <= '0;
                        out_vld    <= 1'b1;
                        out_dat    <= mem[ul_ptr][0];
                        out_last   <= (cnt[ul_ptr] == NW'(1));
                        out_err    <= err_f[ul_ptr];
                        u_st       <= U_RUN;
                    end
                end
                U_RUN: begin
                    if (out_rdy) begin
                        if (out_last) begin
                            st[ul_ptr]     <= B_IDLE;
                            cnt[ul_ptr]    <= '0;
                            err_f[ul_ptr]  <= 1'b0;
                            desc_f[ul_ptr] <= 1'b0;
                            ul_ptr         <= nxt(ul_ptr);
                            out_vld        <= 1'b0;
                            out_last       <= 1'b0;
                            out_err        <= 1'b0;
                            u_st           <= U_IDLE;
                        end else begin
                            u_idx    <= u_nxt;
                            out_dat  <= mem[ul_ptr][u_nxt];
                            out_last <= ({1'b0, u_nxt} + NW'(1) == cnt[ul_ptr]);
                        end
                    end
                end
                default: u_st <= U_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int b = 0; b < BANK_N; b++) begin
            if (st[b] != B_IDLE) busy = 1'b1;
        end
    end
endmodule

// File: tb/tb_banked_sort_engine.sv
// Directed bench for banked_sort_engine: ordering, truncation, backpressure, sort latency and reset recovery.
module tb_banked_sort_engine;
    localparam int N      = 16;
    localparam int W      = 32;
    localparam int BANK_N = 2;
`ifdef BANKED_SORT_EARLY_EXIT_EN
    localparam int LAT_ORDERED4 = 6;
`else
    localparam int LAT_ORDERED4 = 9;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_vld = 1'b0;
    logic [W-1:0] in_dat = '0;
    logic         in_last = 1'b0;
    logic         in_desc = 1'b0;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_dat;
    logic         out_last;
    logic         out_err;
    logic         out_rdy = 1'b0;
    logic         busy;

    banked_sort_engine #(.N(N), .W(W), .BANK_N(BANK_N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_dat(in_dat), .in_last(in_last), .in_desc(in_desc), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_dat(out_dat), .out_last(out_last), .out_err(out_err), .out_rdy(out_rdy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int acc_cyc  = 0;
    logic [W-1:0] exp_q [0:31];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic last, input logic desc);
        int k;
        in_vld  = 1'b1;
        in_dat  = d;
        in_last = last;
        in_desc = desc;
        k = 0;
        while (!in_rdy && k < 300) begin
            step();
            k++;
        end
        chk("push_rdy", W'(in_rdy), W'(1));
        step();
        acc_cyc = cyc;
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_out(input int budget);
        int k;
        k = 0;
        while (!out_vld && k < budget) begin
            step();
            k++;
        end
        chk("out_vld_wait", W'(out_vld), W'(1));
    endtask

    task automatic check_list(input int len, input logic exp_err, input string tag);
        for (int i = 0; i < len; i++) begin
            wait_out(400);
            chk($sformatf("%s_dat%0d", tag, i), out_dat, exp_q[i]);
            chk($sformatf("%s_last%0d", tag, i), W'(out_last), W'(i == len - 1));
            chk($sformatf("%s_err%0d", tag, i), W'(out_err), W'(exp_err));
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_in_rdy", W'(in_rdy), W'(0));
        chk("rst_out_vld", W'(out_vld), W'(0));
        chk("rst_out_last", W'(out_last), W'(0));
        chk("rst_out_err", W'(out_err), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_rdy", W'(in_rdy), W'(1));
        out_rdy = 1'b1;

        // Ascending 5,3,9,1: six compares, latency 3 + 6 edges
        push(5, 0, 0); push(3, 0, 0); push(9, 0, 0); push(1, 1, 0);
        wait_out(200);
        chk("lat_asc4", W'(cyc - acc_cyc), W'(9));
        exp_q[0] = 1; exp_q[1] = 3; exp_q[2] = 5; exp_q[3] = 9;
        check_list(4, 1'b0, "asc4");

        // Single word: no compares
        push(42, 1, 0);
        wait_out(200);
        chk("lat_single", W'(cyc - acc_cyc), W'(3));
        exp_q[0] = 42;
        check_list(1, 1'b0, "single");

        // Already ordered input
        push(1, 0, 0); push(2, 0, 0); push(3, 0, 0); push(4, 1, 0);
        wait_out(200);
        chk("lat_ordered4", W'(cyc - acc_cyc), W'(LAT_ORDERED4));
        exp_q[0] = 1; exp_q[1] = 2; exp_q[2] = 3; exp_q[3] = 4;
        check_list(4, 1'b0, "ordered4");

        // Truncation at N, descending, overflow word forms next list
        for (int i = 0; i < N; i++) push(W'(i), 0, 1);
        push(7, 1, 0);
        for (int i = 0; i < N; i++) exp_q[i] = W'(N - 1 - i);
        check_list(N, 1'b1, "trunc");
        exp_q[0] = 7;
        check_list(1, 1'b0, "ovf");

        // Backpressure with all banks occupied
        out_rdy = 1'b0;
        push(20, 0, 0); push(10, 1, 0);
        push(30, 1, 0);
        chk("full_in_rdy", W'(in_rdy), W'(0));
        wait_out(200);
        chk("bp_dat0", out_dat, W'(10));
        step(); step(); step();
        chk("bp_hold_dat", out_dat, W'(10));
        chk("bp_hold_last", W'(out_last), W'(0));
        chk("bp_hold_in_rdy", W'(in_rdy), W'(0));
        out_rdy = 1'b1;
        step();
        chk("bp_dat1", out_dat, W'(20));
        chk("bp_last1", W'(out_last), W'(1));
        chk("bp_in_rdy_before", W'(in_rdy), W'(0));
        step();
        chk("bp_in_rdy_after", W'(in_rdy), W'(1));
        out_rdy = 1'b0;
        push(40, 1, 0);
        out_rdy = 1'b1;
        exp_q[0] = 30;
        check_list(1, 1'b0, "listB");
        exp_q[0] = 40;
        check_list(1, 1'b0, "listC");

        // Reset while sorting
        for (int i = 8; i >= 1; i--) push(W'(i), i == 1, 0);
        step(); step(); step(); step(); step();
        chk("sorting_busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("rs_out_vld", W'(out_vld), W'(0));
        chk("rs_busy", W'(busy), W'(0));
        chk("rs_in_rdy", W'(in_rdy), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rs_in_rdy_after", W'(in_rdy), W'(1));

        // Reset while unloading with out_rdy toggling
        out_rdy = 1'b0;
        push(3, 0, 0); push(1, 0, 0); push(2, 1, 0);
        wait_out(200);
        chk("ru_dat0", out_dat, W'(1));
        out_rdy = 1'b1;
        step();
        chk("ru_dat1", out_dat, W'(2));
        out_rdy = 1'b0;
        step();
        chk("ru_hold_dat1", out_dat, W'(2));
        out_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("ru_out_vld", W'(out_vld), W'(0));
        chk("ru_out_dat", out_dat, W'(0));
        chk("ru_out_last", W'(out_last), W'(0));
        chk("ru_out_err", W'(out_err), W'(0));
        chk("ru_busy", W'(busy), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ru_in_rdy_after", W'(in_rdy), W'(1));

        // Fresh list after reset, descending
        push(6, 0, 1); push(2, 0, 1); push(4, 1, 1);
        wait_out(200);
        chk("lat_desc3", W'(cyc - acc_cyc), W'(6));
        exp_q[0] = 6; exp_q[1] = 4; exp_q[2] = 2;
        check_list(3, 1'b0, "desc3");
        step();
        chk("end_busy", W'(busy), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
